entrada_decimal: RTL and testbench



---
 rtl/entrada_decimal_pkg.sv | 10 +
 rtl/entrada_decimal_debounce_tecla.sv | 45 ++++
 rtl/entrada_decimal.sv | 110 +++++++++++
 tb/tb_entrada_decimal.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/entrada_decimal_pkg.sv
// Shared definitions for the decimal keypad entry block: FSM encoding and the BCD digit limit.
package entrada_decimal_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/entrada_decimal_debounce_tecla.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, one pulse per debounced press.
module debounce_tecla #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so all flops sample the
  // pre-edge values; blocking would collapse the synchronizer into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pulse <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entrada_decimal.sv
// Decimal keypad entry: stalls the CPU, assembles typed BCD digits into a binary word.
// Optional digit echo outputs for the 7-segment path when ENTRADA_ECO_EN is defined.
module entrada_decimal
  import entrada_decimal_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int WIDTH      = 32,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       digit,
  input  logic             key_digit_n,
  input  logic             key_enter_n,
  input  logic             key_clear_n,
  output logic             halt,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic [3:0]       count,
  output logic             err
`ifdef ENTRADA_ECO_EN
 ,output logic [3:0]       eco_mil,
  output logic [3:0]       eco_cent,
  output logic [3:0]       eco_dez,
  output logic [3:0]       eco_uni
`endif
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic             digit_p;
  logic             enter_p;
  logic             clear_p;

  debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb_digit (
    .clk(clk), .reset(reset), .key_n(key_digit_n), .pulse(digit_p));
  debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk(clk), .reset(reset), .key_n(key_enter_n), .pulse(enter_p));
  debounce_tecla #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk(clk), .reset(reset), .key_n(key_clear_n), .pulse(clear_p));

  function automatic logic [WIDTH-1:0] mul10_add(input logic [WIDTH-1:0] a,
                                                 input logic [3:0] d);
    return (a << 3) + (a << 1) + WIDTH'(d);
  endfunction

  assign halt  = (state == ST_COLLECT);
  assign valid = (state == ST_DONE);

  logic digit_ok;
  assign digit_ok = (digit <= BCD_MAX) && (count < MAX_CNT);

`ifdef ENTRADA_ECO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      {eco_mil, eco_cent, eco_dez, eco_uni} <= '0;
    end else if ((state == ST_IDLE && req) || (state == ST_COLLECT && !enter_p && clear_p)) begin
      {eco_mil, eco_cent, eco_dez, eco_uni} <= '0;
    end else if (state == ST_COLLECT && !enter_p && digit_p && digit_ok) begin
      {eco_mil, eco_cent, eco_dez, eco_uni} <= {eco_cent, eco_dez, eco_uni, digit};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      count <= '0;
      err   <= 1'b0;
      value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_COLLECT;
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
          end
        end
        ST_COLLECT: begin
          // Priority enter > clear > digit; lower-priority pulses in the same cycle are lost.
          if (enter_p) begin
            value <= acc;
            err   <= 1'b0;
            state <= ST_DONE;
          end else if (clear_p) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
          end else if (digit_p) begin
            if (digit > BCD_MAX) begin
              err <= 1'b1;
            end else if (count < MAX_CNT) begin
              acc   <= mul10_add(acc, digit);
              count <= count + 4'd1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_decimal.sv
// Self-checking bench for entrada_decimal: scoreboard of expected values popped on each valid pulse.
module tb_entrada_decimal;

  localparam int MAX_DIGITS = 4;
  localparam int WIDTH      = 32;
  localparam int DEB        = 8;
  localparam int HOLD       = DEB + 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [3:0]       digit;
  logic             key_digit_n;
  logic             key_enter_n;
  logic             key_clear_n;
  logic             halt;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic [3:0]       count;
  logic             err;
`ifdef ENTRADA_ECO_EN
  logic [3:0]       eco_mil, eco_cent, eco_dez, eco_uni;
`endif

  entrada_decimal #(.MAX_DIGITS(MAX_DIGITS), .WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .req(req), .digit(digit),
    .key_digit_n(key_digit_n), .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
    .halt(halt), .value(value), .valid(valid), .count(count), .err(err)
`ifdef ENTRADA_ECO_EN
   ,.eco_mil(eco_mil), .eco_cent(eco_cent), .eco_dez(eco_dez), .eco_uni(eco_uni)
`endif
  );

  always #5 clk = ~clk;

  int              n_cmp = 0;
  int              n_bad = 0;
  int              valid_seen = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      valid_seen++;
      check("halt_at_valid", 32'(halt), 0);
      if (sb.size() == 0) check("sb_has_entry_at_valid", 0, 1);
      else                check("value", value, sb.pop_front());
    end
  end

  // 0 = digit, 1 = enter, 2 = clear
  task automatic press(input int k, input logic [3:0] d);
    @(negedge clk);
    digit = d;
    case (k)
      0: key_digit_n = 1'b0;
      1: key_enter_n = 1'b0;
      default: key_clear_n = 1'b0;
    endcase
    repeat (HOLD) @(negedge clk);
    key_digit_n = 1'b1;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic start_entry();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("halt_after_req", 32'(halt), 1);
    check("count_at_start", 32'(count), 0);
  endtask

  task automatic finish_entry(input logic [WIDTH-1:0] exp);
    sb.push_back(exp);
    valid_seen = 0;
    press(1, 4'd0);
    check("valid_cycles", valid_seen, 1);
    check("sb_drained", sb.size(), 0);
    check("halt_after_done", 32'(halt), 0);
    check("value_held", value, exp);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; digit = 4'd0;
    key_digit_n = 1'b1; key_enter_n = 1'b1; key_clear_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_halt", 32'(halt), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_value", value, 0);
    check("rst_count", 32'(count), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;

    // Key press in IDLE must be discarded
    press(0, 4'd3);
    check("idle_key_count", 32'(count), 0);
    check("idle_key_halt", 32'(halt), 0);

    // 1,2,3,4 -> 1234
    start_entry();
    foreach (sb[i]) ; // no-op, keeps queue idle
    press(0, 4'd1); press(0, 4'd2); press(0, 4'd3); press(0, 4'd4);
    check("t1_count", 32'(count), 4);
    check("t1_halt", 32'(halt), 1);
`ifdef ENTRADA_ECO_EN
    check("t1_eco", {16'd0, eco_mil, eco_cent, eco_dez, eco_uni}, 32'h1234);
`endif
    finish_entry(32'd1234);

    // 9,9,9,9,7 -> fifth digit ignored
    start_entry();
    press(0, 4'd9); press(0, 4'd9); press(0, 4'd9); press(0, 4'd9); press(0, 4'd7);
    check("t2_count", 32'(count), 4);
    check("t2_err", 32'(err), 0);
    finish_entry(32'd9999);

    // invalid digit sets err, then 5
    start_entry();
    press(0, 4'hC);
    check("t3_err", 32'(err), 1);
    check("t3_count", 32'(count), 0);
    press(0, 4'd5);
    check("t3_err_sticky", 32'(err), 1);
    finish_entry(32'd5);
    check("t3_err_cleared", 32'(err), 0);

    // 8,1, clear, 6 -> 6
    start_entry();
    press(0, 4'd8); press(0, 4'd1);
    press(2, 4'd0);
    check("t4_count_clr", 32'(count), 0);
    press(0, 4'd6);
    finish_entry(32'd6);

    // bounce then one stable press
    start_entry();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); digit = 4'd7; key_digit_n = 1'b0;
      repeat (2) @(negedge clk); key_digit_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    press(0, 4'd7);
    check("t5_bounce_count", 32'(count), 1);
    // enter and digit together -> digit dropped
    sb.push_back(32'd7);
    valid_seen = 0;
    @(negedge clk); digit = 4'd3; key_digit_n = 1'b0; key_enter_n = 1'b0;
    repeat (HOLD) @(negedge clk);
    key_digit_n = 1'b1; key_enter_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check("t5_valid_cycles", valid_seen, 1);
    check("t5_sb_drained", sb.size(), 0);
    check("t5_value", value, 32'd7);

    // enter with no digits -> 0
    start_entry();
    finish_entry(32'd0);

    // reset mid-entry after 4,2
    start_entry();
    press(0, 4'd4); press(0, 4'd2);
    check("t6_count", 32'(count), 2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t6_halt", 32'(halt), 0);
    check("t6_count_rst", 32'(count), 0);
    check("t6_value", value, 32'd0);
    check("t6_valid", 32'(valid), 0);
`ifdef ENTRADA_ECO_EN
    check("t6_eco", {16'd0, eco_mil, eco_cent, eco_dez, eco_uni}, 32'h0);
`endif
    repeat (4) @(negedge clk);
    check("t6_stays_idle", 32'(halt), 0);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
